pc_sequencer: RTL and testbench

Fetch-side controller for the 64-bit program counter in the pipelined CPU. It owns the PC register and decides the next fetch address every cycle. Candidates are sequential (+4), branch target, register-jump target and trap vector. It also handles a short boot hold, stalls, redirects that arrive while stalled, and halt/resume. It drives the fetch address, fetch-valid and a one-cycle pipeline flush.

---
 rtl/pc_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Fetch-side program counter controller. Owns the 64-bit PC and picks the
// next fetch address every cycle. The candidates are:
//   - sequential pc+4
//   - branch target
//   - register-jump target
//   - trap vector
//   - a redirect that was parked while decode was stalling
// It also sequences a short boot hold after reset and a halt/resume handshake.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_ni       asynchronous active-low reset
//   stall_i        hazard stall from decode; PC is held
//   br_taken_i     resolved conditional branch taken
//   br_target_i    branch target (64 bits)
//   jr_valid_i     register jump resolved
//   jr_target_i    register-jump target (64 bits)
//   trap_i         external / illegal-instruction trap request
//   halt_req_i     stop fetching
//   resume_i       leave HALTED
//   pc_o           current fetch address (registered)
//   fetch_valid_o  pc_o is a real fetch this cycle
//   flush_o        one-cycle pulse that kills younger in-flight instructions
//   trap_taken_o   one-cycle pulse, coincident with pc_o == TRAP_VECTOR
//   cause_o        last trap cause: 0 none, 1 external, 2 misaligned target
//   halted_o       block is in the HALTED state
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter logic [63:0] TRAP_VECTOR  = 64'h100,
  parameter int unsigned BOOT_CYCLES  = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [63:0] br_target_i,
  input  logic        jr_valid_i,
  input  logic [63:0] jr_target_i,
  input  logic        trap_i,
  input  logic        halt_req_i,
  input  logic        resume_i,
  output logic [63:0] pc_o,
  output logic        fetch_valid_o,
  output logic        flush_o,
  output logic        trap_taken_o,
  output logic [1:0]  cause_o,
  output logic        halted_o
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STALLED = 2'd2,
    ST_HALTED  = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_EXT  = 2'd1;
  localparam logic [1:0] CAUSE_MIS  = 2'd2;

  localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  // Counter value seen on the last boot edge; that edge moves to RUN.
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  // A fetch target must be word aligned.
  function automatic logic misaligned(input logic [63:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [63:0]      pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [63:0]      pend_target_q, pend_target_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             flush_q, flush_d;
  logic             trap_taken_q, trap_taken_d;
  logic [1:0]       cause_q, cause_d;
  logic             halted_q, halted_d;

  logic             live_valid_s;
  logic [63:0]      live_target_s;

  // Live redirect from execute; the register jump beats the branch.
  assign live_valid_s  = jr_valid_i | br_taken_i;
  assign live_target_s = jr_valid_i ? jr_target_i : br_target_i;

  // Next-state, next-PC and pulse generation.
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    flush_d       = 1'b0;
    trap_taken_d  = 1'b0;
    cause_d       = cause_q;

    case (state_q)
      ST_BOOT: begin
        // Inputs are ignored here; pc stays on RESET_VECTOR.
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      ST_RUN, ST_STALLED: begin
        if (trap_i) begin
          pc_d         = TRAP_VECTOR;
          flush_d      = 1'b1;
          trap_taken_d = 1'b1;
          cause_d      = CAUSE_EXT;
          pend_valid_d = 1'b0;
          state_d      = ST_RUN;
        end else if (pend_valid_q && !stall_i) begin
          // The parked redirect is the architecturally correct one; anything
          // resolving in this same cycle belongs to the wrong path.
          pc_d         = pend_target_q;
          flush_d      = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = ST_RUN;
        end else if (live_valid_s) begin
          if (misaligned(live_target_s)) begin
            pc_d         = TRAP_VECTOR;
            flush_d      = 1'b1;
            trap_taken_d = 1'b1;
            cause_d      = CAUSE_MIS;
            pend_valid_d = 1'b0;
            state_d      = ST_RUN;
          end else if (stall_i) begin
            // Park the target; a newer redirect overwrites an older one.
            pend_valid_d  = 1'b1;
            pend_target_d = live_target_s;
            state_d       = ST_STALLED;
          end else begin
            pc_d    = live_target_s;
            flush_d = 1'b1;
            state_d = ST_RUN;
          end
        end else if (stall_i) begin
          state_d = ST_STALLED;
        end else begin
          // A halt without a redirect freezes the current address.
          pc_d    = halt_req_i ? pc_q : (pc_q + 64'd4);
          state_d = ST_RUN;
        end

        // Halt wins over the state chosen above, after the redirect landed.
        if (halt_req_i) begin
          state_d = ST_HALTED;
        end else begin
          state_d = state_d;
        end
      end

      ST_HALTED: begin
        if (trap_i) begin
          pc_d         = TRAP_VECTOR;
          flush_d      = 1'b1;
          trap_taken_d = 1'b1;
          cause_d      = CAUSE_EXT;
          pend_valid_d = 1'b0;
          state_d      = ST_RUN;
        end else if (resume_i && !halt_req_i) begin
          state_d = ST_RUN;
          if (pend_valid_q) begin
            pc_d         = pend_target_q;
            flush_d      = 1'b1;
            pend_valid_d = 1'b0;
          end else begin
            pc_d = pc_q;
          end
        end else begin
          state_d = ST_HALTED;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    fetch_valid_d = (state_d == ST_RUN) || (state_d == ST_STALLED);
    halted_d      = (state_d == ST_HALTED);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= ST_BOOT;
      boot_cnt_q    <= {CNT_W{1'b0}};
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 64'h0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      trap_taken_q  <= 1'b0;
      cause_q       <= CAUSE_NONE;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      trap_taken_q  <= trap_taken_d;
      cause_q       <= cause_d;
      halted_q      <= halted_d;
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign flush_o       = flush_q;
  assign trap_taken_o  = trap_taken_q;
  assign cause_o       = cause_q;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed testbench for pc_sequencer.
// Inputs change 1 ns after a rising edge. Outputs are checked 1 ns after the
// next rising edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        jr_valid;
  logic [63:0] jr_target;
  logic        trap;
  logic        halt_req;
  logic        resume;
  logic [63:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        trap_taken;
  logic [1:0]  cause;
  logic        halted;

  int n_cmp = 0;
  int n_mis = 0;

  pc_sequencer dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .stall_i       (stall),
    .br_taken_i    (br_taken),
    .br_target_i   (br_target),
    .jr_valid_i    (jr_valid),
    .jr_target_i   (jr_target),
    .trap_i        (trap),
    .halt_req_i    (halt_req),
    .resume_i      (resume),
    .pc_o          (pc),
    .fetch_valid_o (fetch_valid),
    .flush_o       (flush),
    .trap_taken_o  (trap_taken),
    .cause_o       (cause),
    .halted_o      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    br_taken = 1'b0;
    jr_valid = 1'b0;
    trap     = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = 64'h0;
    jr_valid  = 1'b0;
    jr_target = 64'h0;
    trap      = 1'b0;
    halt_req  = 1'b0;
    resume    = 1'b0;
    #1;
    // Reset state.
    chk("rst_pc", pc, 64'h0);
    chk("rst_fv", {63'd0, fetch_valid}, 64'd0);
    chk("rst_flush", {63'd0, flush}, 64'd0);
    chk("rst_tt", {63'd0, trap_taken}, 64'd0);
    chk("rst_cause", {62'd0, cause}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);

    // Hold reset for three edges, then release.
    step(); step(); step();
    reset_n = 1'b1;
    chk("boot0_fv", {63'd0, fetch_valid}, 64'd0);
    step();
    chk("boot1_fv", {63'd0, fetch_valid}, 64'd0);
    step();
    chk("run0_fv", {63'd0, fetch_valid}, 64'd1);
    chk("run0_pc", pc, 64'h0);
    chk("run0_flush", {63'd0, flush}, 64'd0);
    step();
    chk("seq_pc4", pc, 64'h4);
    step();
    chk("seq_pc8", pc, 64'h8);
    chk("seq_tt", {63'd0, trap_taken}, 64'd0);

    // Branch at pc=8.
    br_taken = 1'b1; br_target = 64'h40;
    step();
    clear_redirects();
    chk("br_pc", pc, 64'h40);
    chk("br_flush", {63'd0, flush}, 64'd1);
    step();
    chk("br_next_pc", pc, 64'h44);
    chk("br_next_flush", {63'd0, flush}, 64'd0);

    // Jump and branch together: jump wins.
    br_taken = 1'b1; br_target = 64'h40;
    jr_valid = 1'b1; jr_target = 64'h80;
    step();
    clear_redirects();
    chk("jrbr_pc", pc, 64'h80);
    chk("jrbr_flush", {63'd0, flush}, 64'd1);
    step();
    chk("jrbr_next_pc", pc, 64'h84);

    // Get to pc=0x10, then stall for three cycles.
    jr_valid = 1'b1; jr_target = 64'h10;
    step();
    clear_redirects();
    chk("to10_pc", pc, 64'h10);
    stall = 1'b1;
    step();
    chk("stall1_pc", pc, 64'h10);
    chk("stall1_fv", {63'd0, fetch_valid}, 64'd1);
    jr_valid = 1'b1; jr_target = 64'h80;
    step();
    clear_redirects();
    chk("stall2_pc", pc, 64'h10);
    chk("stall2_flush", {63'd0, flush}, 64'd0);
    step();
    chk("stall3_pc", pc, 64'h10);
    // Release the stall; the live branch is wrong-path.
    stall = 1'b0;
    br_taken = 1'b1; br_target = 64'h60;
    step();
    clear_redirects();
    chk("pend_pc", pc, 64'h80);
    chk("pend_flush", {63'd0, flush}, 64'd1);
    step();
    chk("pend_next_pc", pc, 64'h84);
    chk("pend_next_flush", {63'd0, flush}, 64'd0);

    // Park a redirect while stalled, then a trap with a branch.
    stall = 1'b1;
    jr_valid = 1'b1; jr_target = 64'h200;
    step();
    clear_redirects();
    chk("park_pc", pc, 64'h84);
    trap = 1'b1;
    br_taken = 1'b1; br_target = 64'h40;
    step();
    clear_redirects();
    chk("trap_pc", pc, 64'h100);
    chk("trap_tt", {63'd0, trap_taken}, 64'd1);
    chk("trap_cause", {62'd0, cause}, 64'd1);
    chk("trap_flush", {63'd0, flush}, 64'd1);
    stall = 1'b0;
    step();
    chk("trap_clr_pc", pc, 64'h104);
    chk("trap_clr_tt", {63'd0, trap_taken}, 64'd0);
    chk("trap_clr_flush", {63'd0, flush}, 64'd0);

    // Misaligned branch target.
    br_taken = 1'b1; br_target = 64'h42;
    step();
    clear_redirects();
    chk("mis_pc", pc, 64'h100);
    chk("mis_cause", {62'd0, cause}, 64'd2);
    chk("mis_tt", {63'd0, trap_taken}, 64'd1);
    step();
    chk("mis_next_pc", pc, 64'h104);
    chk("mis_hold_cause", {62'd0, cause}, 64'd2);
    chk("mis_next_tt", {63'd0, trap_taken}, 64'd0);

    // Wrap-around of the sequential increment.
    jr_valid = 1'b1; jr_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    clear_redirects();
    chk("wrap_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("wrap_zero", pc, 64'h0);

    // Halt at pc=0x20.
    jr_valid = 1'b1; jr_target = 64'h20;
    step();
    clear_redirects();
    chk("to20_pc", pc, 64'h20);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_fv", {63'd0, fetch_valid}, 64'd0);
    chk("halt_pc", pc, 64'h20);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_hold_pc", pc, 64'h20);
      chk("halt_hold_halted", {63'd0, halted}, 64'd1);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume_halted", {63'd0, halted}, 64'd0);
    chk("resume_fv", {63'd0, fetch_valid}, 64'd1);
    chk("resume_pc", pc, 64'h20);
    chk("resume_flush", {63'd0, flush}, 64'd0);
    step();
    chk("resume_next_pc", pc, 64'h24);

    // Halt and resume together keep the block halted.
    halt_req = 1'b1;
    step();
    chk("halt2_pc", pc, 64'h24);
    resume = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_resume_halted", {63'd0, halted}, 64'd1);
    step();
    resume = 1'b0;
    chk("resume2_halted", {63'd0, halted}, 64'd0);
    chk("resume2_pc", pc, 64'h24);

    // Reset in the middle of a stall with a parked redirect.
    stall = 1'b1;
    jr_valid = 1'b1; jr_target = 64'h300;
    step();
    clear_redirects();
    chk("park2_pc", pc, 64'h24);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 64'h0);
    chk("mid_rst_fv", {63'd0, fetch_valid}, 64'd0);
    chk("mid_rst_cause", {62'd0, cause}, 64'd0);
    stall = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("reboot1_fv", {63'd0, fetch_valid}, 64'd0);
    step();
    chk("reboot_fv", {63'd0, fetch_valid}, 64'd1);
    chk("reboot_pc", pc, 64'h0);
    chk("reboot_flush", {63'd0, flush}, 64'd0);
    step();
    chk("reboot_next_pc", pc, 64'h4);
    chk("reboot_next_flush", {63'd0, flush}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
